// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encodings, request source
// identifiers and the write-strobe width.
package mem_responder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DW   = 2'd1,
        SRC_DR   = 2'd2,
        SRC_IR   = 2'd3
    } src_t;

    localparam int WSTRB_W = 4;

endpackage

// File: rtl/mem_resp_sram.sv
// Single-port on-chip SRAM: 32-bit words, four byte-lane write enables and a
// registered read port that only updates on a read access.
module mem_resp_sram
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic [WSTRB_W-1:0]  we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Byte-lane writes and registered read; rdata holds between reads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WSTRB_W; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint for the MMU physical instruction/data bus. One SRAM
// access per cycle; concurrent requests are parked in pending slots and drained
// in priority order (data write > data read > instruction read) while MEM_WAIT
// stalls the core.
// Optional feature: define MEM_RESP_PERF_EN to add the PERF_STALL_CNT port.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_INST_RDEN,
    input  logic [31:0] MEM_INST_RIADDR,
    output logic [31:0] MEM_INST_ROADDR,
    output logic        MEM_INST_RVALID,
    output logic [31:0] MEM_INST_RDATA,
    input  logic        MEM_DATA_RDEN,
    input  logic [31:0] MEM_DATA_RIADDR,
    output logic [31:0] MEM_DATA_ROADDR,
    output logic        MEM_DATA_RVALID,
    output logic [31:0] MEM_DATA_RDATA,
    input  logic        MEM_DATA_WREN,
    input  logic [3:0]  MEM_DATA_WSTRB,
    input  logic [31:0] MEM_DATA_WADDR,
    input  logic [31:0] MEM_DATA_WDATA,
    output logic        MEM_WAIT
`ifdef MEM_RESP_PERF_EN
    ,
    output logic [31:0] PERF_STALL_CNT
`endif
);

    state_t state, state_nxt;

    // Pending slots
    logic                p_dw_vld;
    logic [ADDR_W-1:0]   p_dw_idx;
    logic [WSTRB_W-1:0]  p_dw_strb;
    logic [31:0]         p_dw_data;
    logic                p_dr_vld;
    logic [31:0]         p_dr_addr;
    logic                p_ir_vld;
    logic [31:0]         p_ir_addr;

    // Request set seen this cycle (inputs in IDLE, pending slots in DRAIN)
    logic                req_dw, req_dr, req_ir;
    logic [ADDR_W-1:0]   cur_dw_idx;
    logic [WSTRB_W-1:0]  cur_dw_strb;
    logic [31:0]         cur_dw_data;
    logic [31:0]         cur_dr_addr;
    logic [31:0]         cur_ir_addr;
    logic [1:0]          n_req;
    src_t                sel;
    logic                nxt_dw_vld, nxt_dr_vld, nxt_ir_vld;

    // SRAM port
    logic [WSTRB_W-1:0]  sram_we;
    logic                sram_re;
    logic [ADDR_W-1:0]   sram_addr;
    logic [31:0]         sram_rdata;

    // Response registers
    logic                data_vld, inst_vld;
    logic [31:0]         data_roaddr, inst_roaddr;
    logic [31:0]         data_hold, inst_hold;

    // Only the word-index bits of the write address are meaningful.
    logic unused_waddr_bits;
    assign unused_waddr_bits = ^{MEM_DATA_WADDR[31:ADDR_W+2], MEM_DATA_WADDR[1:0]};

    // Select request source, pick the winner, compute stall and next slot state.
    always_comb begin
        req_dw      = p_dw_vld;
        req_dr      = p_dr_vld;
        req_ir      = p_ir_vld;
        cur_dw_idx  = p_dw_idx;
        cur_dw_strb = p_dw_strb;
        cur_dw_data = p_dw_data;
        cur_dr_addr = p_dr_addr;
        cur_ir_addr = p_ir_addr;
        if (state == ST_IDLE) begin
            req_dw      = MEM_DATA_WREN;
            req_dr      = MEM_DATA_RDEN;
            req_ir      = MEM_INST_RDEN;
            cur_dw_idx  = MEM_DATA_WADDR[ADDR_W+1:2];
            cur_dw_strb = MEM_DATA_WSTRB;
            cur_dw_data = MEM_DATA_WDATA;
            cur_dr_addr = MEM_DATA_RIADDR;
            cur_ir_addr = MEM_INST_RIADDR;
        end
        // Nothing is served while reset is held.
        if (!RST) begin
            req_dw = 1'b0;
            req_dr = 1'b0;
            req_ir = 1'b0;
        end

        sel = SRC_NONE;
        if (req_dw) begin
            sel = SRC_DW;
        end else if (req_dr) begin
            sel = SRC_DR;
        end else if (req_ir) begin
            sel = SRC_IR;
        end

        n_req    = {1'b0, req_dw} + {1'b0, req_dr} + {1'b0, req_ir};
        MEM_WAIT = (n_req > 2'd1);

        nxt_dw_vld = req_dw && (sel != SRC_DW);
        nxt_dr_vld = req_dr && (sel != SRC_DR);
        nxt_ir_vld = req_ir && (sel != SRC_IR);
        state_nxt  = (nxt_dw_vld || nxt_dr_vld || nxt_ir_vld) ? ST_DRAIN : ST_IDLE;

        sram_we   = '0;
        sram_re   = 1'b0;
        sram_addr = cur_dw_idx;
        case (sel)
            SRC_DW: begin
                sram_we   = cur_dw_strb;
                sram_addr = cur_dw_idx;
            end
            SRC_DR: begin
                sram_re   = 1'b1;
                sram_addr = cur_dr_addr[ADDR_W+1:2];
            end
            SRC_IR: begin
                sram_re   = 1'b1;
                sram_addr = cur_ir_addr[ADDR_W+1:2];
            end
            default: ;
        endcase
    end

    // FSM state and pending slots; payloads captured whenever the FSM is idle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_IDLE;
            p_dw_vld <= 1'b0;
            p_dr_vld <= 1'b0;
            p_ir_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            p_dw_vld <= nxt_dw_vld;
            p_dr_vld <= nxt_dr_vld;
            p_ir_vld <= nxt_ir_vld;
        end
        if (state == ST_IDLE) begin
            p_dw_idx  <= cur_dw_idx;
            p_dw_strb <= cur_dw_strb;
            p_dw_data <= cur_dw_data;
            p_dr_addr <= cur_dr_addr;
            p_ir_addr <= cur_ir_addr;
        end
    end

    mem_resp_sram #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (CLK),
        .we    (sram_we),
        .re    (sram_re),
        .addr  (sram_addr),
        .wdata (cur_dw_data),
        .rdata (sram_rdata)
    );

    // Response valids, echoed addresses and per-port copies of the last read word.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            data_vld    <= 1'b0;
            inst_vld    <= 1'b0;
            data_roaddr <= '0;
            inst_roaddr <= '0;
            data_hold   <= '0;
            inst_hold   <= '0;
        end else begin
            data_vld <= (sel == SRC_DR);
            inst_vld <= (sel == SRC_IR);
            if (sel == SRC_DR) begin
                data_roaddr <= cur_dr_addr;
            end
            if (sel == SRC_IR) begin
                inst_roaddr <= cur_ir_addr;
            end
            if (data_vld) begin
                data_hold <= sram_rdata;
            end
            if (inst_vld) begin
                inst_hold <= sram_rdata;
            end
        end
    end

    // The SRAM output is shared, so each port shows it only on its own valid cycle.
    assign MEM_DATA_RVALID = data_vld;
    assign MEM_DATA_ROADDR = data_roaddr;
    assign MEM_DATA_RDATA  = data_vld ? sram_rdata : data_hold;
    assign MEM_INST_RVALID = inst_vld;
    assign MEM_INST_ROADDR = inst_roaddr;
    assign MEM_INST_RDATA  = inst_vld ? sram_rdata : inst_hold;

`ifdef MEM_RESP_PERF_EN
    logic [31:0] stall_cnt;

    // Count every stalled cycle; wraps naturally.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            stall_cnt <= '0;
        end else if (MEM_WAIT) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign PERF_STALL_CNT = stall_cnt;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus hand sequences for
// drain, reset and the optional stall counter (MEM_RESP_PERF_EN).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_rden = 1'b0;
    logic [31:0] inst_riaddr = '0;
    logic [31:0] inst_roaddr;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_rden = 1'b0;
    logic [31:0] data_riaddr = '0;
    logic [31:0] data_roaddr;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_wren = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_waddr = '0;
    logic [31:0] data_wdata = '0;
    logic        mem_wait;
`ifdef MEM_RESP_PERF_EN
    logic [31:0] perf_cnt;
`endif

    mem_responder #(.ADDR_W(12)) dut (
        .CLK             (clk),
        .RST             (rst),
        .MEM_INST_RDEN   (inst_rden),
        .MEM_INST_RIADDR (inst_riaddr),
        .MEM_INST_ROADDR (inst_roaddr),
        .MEM_INST_RVALID (inst_rvalid),
        .MEM_INST_RDATA  (inst_rdata),
        .MEM_DATA_RDEN   (data_rden),
        .MEM_DATA_RIADDR (data_riaddr),
        .MEM_DATA_ROADDR (data_roaddr),
        .MEM_DATA_RVALID (data_rvalid),
        .MEM_DATA_RDATA  (data_rdata),
        .MEM_DATA_WREN   (data_wren),
        .MEM_DATA_WSTRB  (data_wstrb),
        .MEM_DATA_WADDR  (data_waddr),
        .MEM_DATA_WDATA  (data_wdata),
        .MEM_WAIT        (mem_wait)
`ifdef MEM_RESP_PERF_EN
        ,
        .PERF_STALL_CNT  (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        dr;
        logic [31:0] draddr;
        logic        ir;
        logic [31:0] iraddr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    resp_t       data_q[$];
    resp_t       inst_q[$];
    logic [31:0] mdl [4096];
    logic [31:0] last_d_addr = '0;
    logic [31:0] last_d_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every valid pulse.
    always @(negedge clk) begin
        resp_t e;
        if (inst_rvalid && data_rvalid) check("one_rvalid", 32'd1, 32'd0);
        if (data_rvalid) begin
            if (data_q.size() == 0) begin
                check("unexpected_data_rvalid", data_roaddr, 32'hFFFF_FFFF);
            end else begin
                e = data_q.pop_front();
                check("data_cycle", cyc, e.cyc);
                check("data_roaddr", data_roaddr, e.addr);
                check("data_rdata", data_rdata, e.data);
                last_d_addr = e.addr;
                last_d_data = e.data;
            end
        end
        if (inst_rvalid) begin
            if (inst_q.size() == 0) begin
                check("unexpected_inst_rvalid", inst_roaddr, 32'hFFFF_FFFF);
            end else begin
                e = inst_q.pop_front();
                check("inst_cycle", cyc, e.cyc);
                check("inst_roaddr", inst_roaddr, e.addr);
                check("inst_rdata", inst_rdata, e.data);
            end
        end
    end

    task automatic zero_inputs();
        data_wren = 1'b0; data_wstrb = '0; data_waddr = '0; data_wdata = '0;
        data_rden = 1'b0; data_riaddr = '0;
        inst_rden = 1'b0; inst_riaddr = '0;
    endtask

    task automatic drive_noise();
        data_wren = 1'b1; data_wstrb = 4'hF; data_waddr = 32'h200; data_wdata = 32'h5555_5555;
        data_rden = 1'b1; data_riaddr = 32'h40;
        inst_rden = 1'b1; inst_riaddr = 32'h40;
    endtask

    // Drive one request group (called just after a rising edge) and follow its drain.
    task automatic issue(input vec_t v, input bit noise);
        int n;
        int slot;
        int k;
        resp_t r;
        logic [11:0] idx;
        n = 0; slot = 0; k = cyc;
        data_wren = v.wr; data_wstrb = v.strb; data_waddr = v.waddr; data_wdata = v.wdata;
        data_rden = v.dr; data_riaddr = v.draddr;
        inst_rden = v.ir; inst_riaddr = v.iraddr;
        if (v.wr) begin
            idx = v.waddr[13:2];
            for (int b = 0; b < 4; b++) if (v.strb[b]) mdl[idx][b*8 +: 8] = v.wdata[b*8 +: 8];
            slot++; n++;
        end
        if (v.dr) begin
            r.addr = v.draddr; r.data = mdl[v.draddr[13:2]]; r.cyc = k + slot + 1;
            data_q.push_back(r);
            slot++; n++;
        end
        if (v.ir) begin
            r.addr = v.iraddr; r.data = mdl[v.iraddr[13:2]]; r.cyc = k + slot + 1;
            inst_q.push_back(r);
            slot++; n++;
        end
        @(negedge clk);
        check("wait_first", {31'b0, mem_wait}, {31'b0, (n > 1)});
        for (int s = 1; s < n; s++) begin
            @(posedge clk); #1;
            if (noise) drive_noise(); else zero_inputs();
            @(negedge clk);
            check("wait_drain", {31'b0, mem_wait}, {31'b0, ((n - s) > 1)});
        end
        @(posedge clk); #1;
        zero_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];
    vec_t v;

    initial begin
        for (int i = 0; i < 4096; i++) mdl[i] = '0;

        //            wr    strb   waddr         wdata          dr    draddr        ir    iraddr
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 32'h0,        1'b1, 32'h0000_0100};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0040, 32'h1122_3344, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h3, 32'h0000_0040, 32'hAAAA_5555, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 32'h0000_0043, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 4'hF, 32'h0000_0080, 32'hCAFE_F00D, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080};
        vecs[6]  = '{1'b1, 4'hF, 32'h0000_0084, 32'h0102_0304, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 32'h0000_0084, 1'b1, 32'h0000_0040};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b1, 32'h0000_0100};
        vecs[9]  = '{1'b1, 4'hC, 32'h0000_4084, 32'h7766_0000, 1'b1, 32'h0000_0085, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 32'h0,        1'b1, 32'h0001_0040};
        vecs[11] = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 32'h0000_0080, 1'b1, 32'h0000_0084};

        // Reset; requests present while reset is low must not stall.
        idle(2);
        data_rden = 1'b1; data_riaddr = 32'h10;
        inst_rden = 1'b1; inst_riaddr = 32'h14;
        @(negedge clk);
        check("wait_in_reset", {31'b0, mem_wait}, 32'd0);
        idle(1);
        zero_inputs();
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_inst_rvalid", {31'b0, inst_rvalid}, 32'd0);
        check("rst_data_rvalid", {31'b0, data_rvalid}, 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        check("rst_inst_roaddr", inst_roaddr, 32'd0);
        check("rst_data_roaddr", data_roaddr, 32'd0);
        check("rst_wait", {31'b0, mem_wait}, 32'd0);
`ifdef MEM_RESP_PERF_EN
        check("rst_perf", perf_cnt, 32'd0);
`endif
        idle(1);

        for (int i = 0; i < 12; i++) issue(vecs[i], 1'b0);
        idle(3);

        // Outputs hold their last value while RVALID is low.
        check("hold_data_rdata", data_rdata, last_d_data);
        check("hold_data_roaddr", data_roaddr, last_d_addr);

        // Inputs changed during DRAIN must be ignored.
        v = '{1'b1, 4'hF, 32'h200, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 32'h0};
        issue(v, 1'b0);
        v = '{1'b1, 4'hF, 32'h0C0, 32'hAAAA_AAAA, 1'b1, 32'h0C0, 1'b1, 32'h100};
        issue(v, 1'b1);
        idle(3);
        v = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0};
        issue(v, 1'b0);
        idle(3);

        // Reset on the second cycle of a three-way conflict.
        data_wren = 1'b1; data_wstrb = 4'hF; data_waddr = 32'h300; data_wdata = 32'h1234_5678;
        data_rden = 1'b1; data_riaddr = 32'h40;
        inst_rden = 1'b1; inst_riaddr = 32'h100;
        mdl[12'h0C0] = 32'h1234_5678;
        @(negedge clk);
        check("rstmid_wait_t", {31'b0, mem_wait}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        zero_inputs();
        @(negedge clk);
        check("rstmid_wait_low", {31'b0, mem_wait}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_data_rdata", data_rdata, 32'd0);
        check("rstmid_data_roaddr", data_roaddr, 32'd0);
        check("rstmid_inst_rdata", inst_rdata, 32'd0);
        check("rstmid_inst_roaddr", inst_roaddr, 32'd0);
        check("rstmid_wait", {31'b0, mem_wait}, 32'd0);
        idle(4);
        v = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0};
        issue(v, 1'b0);
        idle(3);

`ifdef MEM_RESP_PERF_EN
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        check("perf_after_rst", perf_cnt, 32'd0);
        idle(1);
        issue(vecs[5], 1'b0);
        issue(vecs[5], 1'b0);
        idle(3);
        check("perf_two_conflicts", perf_cnt, 32'd4);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        check("perf_cleared", perf_cnt, 32'd0);
        idle(1);
`endif

        check("data_q_drained", data_q.size(), 32'd0);
        check("inst_q_drained", inst_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
